// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared opcode enums and FSM state encoding for the vector execute stage
package asip_pkg;

    typedef enum logic [1:0] {
        OP_SCALAR = 2'b00,
        OP_VV     = 2'b01,
        OP_VS     = 2'b10,
        OP_NOP    = 2'b11
    } op_type_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_BUSY = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/vector_execute_stage_if.sv
// rtl/vector_execute_stage_if.sv - ID/EX operand bus and execute-stage result bus
interface vector_execute_stage_if #(
    parameter int N = 32,
    parameter int L = 8,
    parameter int V = 20
);
    logic                  start_i;
    logic [1:0]            OpType_i;
    logic [1:0]            ALUControl_i;
    logic                  ALUSource_i;
    logic                  SetFlags_i;
    logic [N-1:0]          RD1_S_i;
    logic [N-1:0]          RD2_S_i;
    logic [N-1:0]          Extend_i;
    logic [V-1:0][L-1:0]   RD1_V_i;
    logic [V-1:0][L-1:0]   RD2_V_i;
    logic [N-1:0]          result_S_o;
    logic [V-1:0][L-1:0]   result_V_o;
    logic [3:0]            flags_o;
    logic                  busy_o;
    logic                  Exe_Finished_o;

    modport slave (
        input  start_i, OpType_i, ALUControl_i, ALUSource_i, SetFlags_i,
        input  RD1_S_i, RD2_S_i, Extend_i, RD1_V_i, RD2_V_i,
        output result_S_o, result_V_o, flags_o, busy_o, Exe_Finished_o
    );

    modport master (
        output start_i, OpType_i, ALUControl_i, ALUSource_i, SetFlags_i,
        output RD1_S_i, RD2_S_i, Extend_i, RD1_V_i, RD2_V_i,
        input  result_S_o, result_V_o, flags_o, busy_o, Exe_Finished_o
    );
endinterface

// File: rtl/vector_lane_alu.sv
// rtl/vector_lane_alu.sv - one L-bit vector lane ALU; VEC_SATURATE_EN selects unsigned saturating add/sub
module vector_lane_alu
    import asip_pkg::*;
#(
    parameter int L = 8
) (
    input  logic [L-1:0] a_i,
    input  logic [L-1:0] b_i,
    input  alu_ctrl_e    ctrl_i,
    output logic [L-1:0] y_o
);

`ifdef VEC_SATURATE_EN
    logic [L:0] sum_w;
    logic [L:0] dif_w;

    // Widened add/sub so the carry/borrow can drive the clamp
    always_comb begin
        sum_w = {1'b0, a_i} + {1'b0, b_i};
        dif_w = {1'b0, a_i} - {1'b0, b_i};
        case (ctrl_i)
            ALU_ADD: y_o = sum_w[L] ? {L{1'b1}} : sum_w[L-1:0];
            ALU_SUB: y_o = dif_w[L] ? {L{1'b0}} : dif_w[L-1:0];
            ALU_AND: y_o = a_i & b_i;
            default: y_o = a_i | b_i;
        endcase
    end
`else
    // Plain modulo-2^L lane arithmetic
    always_comb begin
        case (ctrl_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            default: y_o = a_i | b_i;
        endcase
    end
`endif

endmodule

// File: rtl/vector_execute_stage.sv
// rtl/vector_execute_stage.sv - multi-cycle scalar/vector execute stage, P lanes per cycle (VEC_SATURATE_EN in lanes)
module vector_execute_stage
    import asip_pkg::*;
#(
    parameter int N = 32,
    parameter int L = 8,
    parameter int V = 20,
    parameter int P = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    vector_execute_stage_if.slave  bus
);

    localparam int IDX_W = (V > 1) ? $clog2(V) : 1;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    op_type_e             op_q;
    alu_ctrl_e            ctrl_q;
    logic [L-1:0]         b_q;
    logic [V-1:0][L-1:0]  rd1_v_q;
    logic [V-1:0][L-1:0]  rd2_v_q;
    logic [V-1:0][L-1:0]  work_q;
    logic [V-1:0][L-1:0]  work_d;
    logic [V-1:0][L-1:0]  result_v_q;
    logic [N-1:0]         result_s_q;
    logic [3:0]           flags_q;

    logic [N-1:0]         b_s;
    logic [N:0]           s_wide;
    logic [N-1:0]         s_res;
    logic                 s_c;
    logic                 s_v;
    logic [3:0]           s_flags;

    logic [P-1:0][L-1:0]  lane_a;
    logic [P-1:0][L-1:0]  lane_b;
    logic [P-1:0][L-1:0]  lane_y;

    // Scalar ALU on the live ID/EX operands; its result is captured on the start edge
    always_comb begin
        b_s    = bus.ALUSource_i ? bus.Extend_i : bus.RD2_S_i;
        s_wide = '0;
        s_res  = '0;
        s_c    = 1'b0;
        s_v    = 1'b0;
        case (alu_ctrl_e'(bus.ALUControl_i))
            ALU_ADD: begin
                s_wide = {1'b0, bus.RD1_S_i} + {1'b0, b_s};
                s_res  = s_wide[N-1:0];
                s_c    = s_wide[N];
                s_v    = (bus.RD1_S_i[N-1] == b_s[N-1]) && (s_res[N-1] != bus.RD1_S_i[N-1]);
            end
            ALU_SUB: begin
                s_wide = {1'b0, bus.RD1_S_i} - {1'b0, b_s};
                s_res  = s_wide[N-1:0];
                s_c    = ~s_wide[N];
                s_v    = (bus.RD1_S_i[N-1] != b_s[N-1]) && (s_res[N-1] != bus.RD1_S_i[N-1]);
            end
            ALU_AND: s_res = bus.RD1_S_i & b_s;
            default: s_res = bus.RD1_S_i | b_s;
        endcase
        s_flags = {s_res[N-1], (s_res == '0), s_c, s_v};
    end

    // Select the P elements addressed by the current index for the lane slice
    always_comb begin
        for (int p = 0; p < P; p++) begin
            lane_a[p] = rd1_v_q[idx_q + IDX_W'(p)];
            lane_b[p] = (op_q == OP_VS) ? b_q : rd2_v_q[idx_q + IDX_W'(p)];
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        vector_lane_alu #(.L(L)) u_lane (
            .a_i    (lane_a[g]),
            .b_i    (lane_b[g]),
            .ctrl_i (ctrl_q),
            .y_o    (lane_y[g])
        );
    end

    // Merge the lane outputs into the working copy of the vector result
    always_comb begin
        work_d = work_q;
        for (int p = 0; p < P; p++) begin
            work_d[idx_q + IDX_W'(p)] = lane_y[p];
        end
    end

    // Control FSM plus operand latching and result/flag registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            op_q       <= OP_NOP;
            ctrl_q     <= ALU_ADD;
            b_q        <= '0;
            rd1_v_q    <= '0;
            rd2_v_q    <= '0;
            work_q     <= '0;
            result_v_q <= '0;
            result_s_q <= '0;
            flags_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        op_q    <= op_type_e'(bus.OpType_i);
                        ctrl_q  <= alu_ctrl_e'(bus.ALUControl_i);
                        b_q     <= b_s[L-1:0];
                        rd1_v_q <= bus.RD1_V_i;
                        rd2_v_q <= bus.RD2_V_i;
                        idx_q   <= '0;
                        if ((op_type_e'(bus.OpType_i) == OP_VV) || (op_type_e'(bus.OpType_i) == OP_VS)) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            if (op_type_e'(bus.OpType_i) == OP_SCALAR) begin
                                result_s_q <= s_res;
                                if (bus.SetFlags_i) begin
                                    flags_q <= s_flags;
                                end
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    work_q <= work_d;
                    idx_q  <= idx_q + IDX_W'(P);
                    // Publish the vector only once the final slice is in, so outputs hold until completion
                    if (idx_q == IDX_W'(V - P)) begin
                        result_v_q <= work_d;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result_S_o     = result_s_q;
    assign bus.result_V_o     = result_v_q;
    assign bus.flags_o        = flags_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.Exe_Finished_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_vector_execute_stage.sv
// tb/tb_vector_execute_stage.sv - directed and random checks of vector_execute_stage against a reference model
module tb_vector_execute_stage;

    localparam int N = 32;
    localparam int L = 8;
    localparam int V = 20;
    localparam int P = 4;

    typedef logic [V-1:0][L-1:0] vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [N-1:0] exp_s;
    logic [3:0]   exp_f;
    vec_t         exp_v;

    int           pend_op;
    logic         pend_setf;
    logic [N-1:0] pend_s;
    logic [3:0]   pend_f;
    vec_t         pend_v;

    vector_execute_stage_if #(.N(N), .L(L), .V(V)) bus ();

    vector_execute_stage #(.N(N), .L(L), .V(V), .P(P)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void scalar_model(input int ctrl, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          sr;
        logic            c;
        logic            v;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (ctrl)
            0: begin
                r  = 32'(ua + ub);
                c  = (ua + ub) >= 64'h1_0000_0000;
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            1: begin
                r  = 32'(ua - ub);
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic [7:0] vec_elem(input int ctrl, input int a, input int b);
        int x;
        case (ctrl)
            0: x = a + b;
            1: x = a - b;
            2: return 8'(a & b);
            default: return 8'(a | b);
        endcase
`ifdef VEC_SATURATE_EN
        if (x > 255) x = 255;
        if (x < 0) x = 0;
`endif
        return 8'(x & 255);
    endfunction

    task automatic drive(input int op, input int ctrl, input logic src, input logic setf,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] ext,
                         input vec_t v1, input vec_t v2);
        bus.OpType_i     = 2'(op);
        bus.ALUControl_i = 2'(ctrl);
        bus.ALUSource_i  = src;
        bus.SetFlags_i   = setf;
        bus.RD1_S_i      = rs1;
        bus.RD2_S_i      = rs2;
        bus.Extend_i     = ext;
        bus.RD1_V_i      = v1;
        bus.RD2_V_i      = v2;
    endtask

    // Expected outcome of the operation currently presented on the bus
    task automatic capture();
        logic [31:0] b;
        int          ctrl;
        b         = bus.ALUSource_i ? bus.Extend_i : bus.RD2_S_i;
        ctrl      = int'(bus.ALUControl_i);
        pend_op   = int'(bus.OpType_i);
        pend_setf = bus.SetFlags_i;
        pend_v    = exp_v;
        pend_s    = exp_s;
        pend_f    = exp_f;
        if (pend_op == 0) begin
            scalar_model(ctrl, bus.RD1_S_i, b, pend_s, pend_f);
        end else if (pend_op == 1 || pend_op == 2) begin
            for (int i = 0; i < V; i++) begin
                pend_v[i] = vec_elem(ctrl, int'(bus.RD1_V_i[i]),
                                     (pend_op == 1) ? int'(bus.RD2_V_i[i]) : int'(b[7:0]));
            end
        end
    endtask

    task automatic commit();
        if (pend_op == 0) begin
            exp_s = pend_s;
            if (pend_setf) exp_f = pend_f;
        end else if (pend_op == 1 || pend_op == 2) begin
            exp_v = pend_v;
        end
    endtask

    // Called just after the accepting edge; counts cycles until the finish pulse
    task automatic wait_done(input string tag);
        int  n;
        int  lat;
        bit  seen;
        lat  = (pend_op == 1 || pend_op == 2) ? (V / P + 1) : 1;
        n    = 1;
        seen = 1'b0;
        while (n <= 20) begin
            check({tag, " busy"}, 192'(bus.busy_o), 192'(1'b1));
            if (bus.Exe_Finished_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 192'(n), 192'(lat));
        if (seen) begin
            commit();
            check({tag, " result_S"}, 192'(bus.result_S_o), 192'(exp_s));
            check({tag, " result_V"}, 192'(bus.result_V_o), 192'(exp_v));
            check({tag, " flags"}, 192'(bus.flags_o), 192'(exp_f));
        end
        @(posedge clk); #1;
        check({tag, " fin_drop"}, 192'(bus.Exe_Finished_o), 192'(1'b0));
        check({tag, " idle"}, 192'(bus.busy_o), 192'(1'b0));
    endtask

    task automatic run_op(input string tag, input int op, input int ctrl, input logic src, input logic setf,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] ext,
                          input vec_t v1, input vec_t v2);
        drive(op, ctrl, src, setf, rs1, rs2, ext, v1, v2);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        capture();
        bus.start_i = 1'b0;
        wait_done(tag);
    endtask

    task automatic check_all_outputs(input string tag);
        check({tag, " result_S"}, 192'(bus.result_S_o), 192'(exp_s));
        check({tag, " result_V"}, 192'(bus.result_V_o), 192'(exp_v));
        check({tag, " flags"}, 192'(bus.flags_o), 192'(exp_f));
        check({tag, " busy"}, 192'(bus.busy_o), 192'(1'b0));
        check({tag, " fin"}, 192'(bus.Exe_Finished_o), 192'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t v2;
        vec_t vz;
        n_vec = 0;
        n_err = 0;
        exp_s = '0;
        exp_f = '0;
        exp_v = '0;
        vz    = '0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        drive(3, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, vz, vz);
        repeat (2) @(posedge clk);
        #1;
        check_all_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add5+7", 0, 0, 1'b1, 1'b1, 32'd5, 32'd99, 32'd7, vz, vz);
        check("add5+7 value", 192'(exp_s), 192'(32'd12));
        run_op("sub3-3", 0, 1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, vz, vz);
        check("sub3-3 flags", 192'(exp_f), 192'(4'b0110));
        run_op("sub_noflags", 0, 1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0, vz, vz);
        run_op("ovf_add", 0, 0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0, vz, vz);
        run_op("carry_add", 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, vz, vz);

        for (int i = 0; i < V; i++) begin
            v1[i] = 8'(i);
            v2[i] = 8'(2 * i);
        end
        run_op("vv_add", 1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, v1, v2);
        for (int i = 0; i < V; i++) begin
            v1[i] = 8'hF0;
        end
        run_op("vs_add_F0", 2, 0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h20, v1, vz);
        run_op("nop", 3, 1, 1'b0, 1'b1, 32'd1, 32'd7, 32'd0, vz, vz);

        // start held high with new operands during a vector op
        for (int i = 0; i < V; i++) begin
            v1[i] = 8'($urandom_range(0, 255));
            v2[i] = 8'($urandom_range(0, 255));
        end
        drive(1, 1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, v1, v2);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        capture();
        drive(2, 3, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0055, v2, v1);
        wait_done("hold_first");
        @(posedge clk); #1;
        capture();
        bus.start_i = 1'b0;
        wait_done("hold_second");

        // reset in the middle of a vector op
        drive(1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, v1, v2);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset busy", 192'(bus.busy_o), 192'(1'b1));
        rst_n = 1'b0;
        #1;
        exp_s = '0;
        exp_f = '0;
        exp_v = '0;
        check_all_outputs("midreset");
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
            check("midreset no_fin", 192'(bus.Exe_Finished_o), 192'(1'b0));
        end
        run_op("post_reset", 0, 0, 1'b0, 1'b1, 32'd40, 32'd2, 32'd0, vz, vz);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < V; i++) begin
                v1[i] = 8'($urandom_range(0, 255));
                v2[i] = 8'($urandom_range(0, 255));
            end
            run_op("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, v1, v2);
        end
        check_all_outputs("final_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_execute_stage.md
VECTOR_EXECUTE_STAGE -- requirements
Module: vector_execute_stage

Interface
REQ-001 Parameter N, default 32, scalar datapath width.
REQ-002 Parameter L, default 8, vector element width.
REQ-003 Parameter V, default 20, elements per vector register.
REQ-004 Parameter P, default 4, lanes processed per cycle; V SHALL be a multiple of P.
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  ID/EX holds a valid operation.
REQ-008 OpType_i  in  2  00 scalar, 01 vector-vector, 10 vector-scalar, 11 NOP.
REQ-009 ALUControl_i  in  2  00 add, 01 sub, 10 and, 11 or.
REQ-010 ALUSource_i  in  1  0: operand B = RD2_S_i, 1: operand B = Extend_i.
REQ-011 SetFlags_i  in  1  update flags on a scalar op.
REQ-012 RD1_S_i, RD2_S_i, Extend_i  in  N each  scalar operands and immediate.
REQ-013 RD1_V_i, RD2_V_i  in  V x L  vector operands.
REQ-014 result_S_o  out  N  scalar result.
REQ-015 result_V_o  out  V x L  vector result.
REQ-016 flags_o  out  4  {N,Z,C,V}.
REQ-017 busy_o  out  1  stage occupied; upstream SHALL hold ID/EX (enable low).
REQ-018 Exe_Finished_o  out  1  one-cycle pulse: results valid.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 In IDLE, start_i high SHALL latch all operands and control, clear the element index, and move to BUSY (vector) or DONE (scalar/NOP).
REQ-021 Scalar op: result_S_o = RD1_S op B, N-bit wrap, registered on the start edge; Exe_Finished_o pulses the following cycle (latency 1).
REQ-022 Vector-vector: element i = RD1_V[i] op RD2_V[i]; vector-scalar: element i = RD1_V[i] op B[L-1:0].
REQ-023 BUSY SHALL process P elements per cycle, index += P; after V/P cycles move to DONE (vector latency V/P+1 cycles from start).
REQ-024 DONE SHALL assert Exe_Finished_o for exactly one cycle, then return to IDLE.
REQ-025 busy_o SHALL be high in BUSY and DONE, low in IDLE.
REQ-026 start_i while busy_o is high SHALL be ignored; latched operands SHALL not change.
REQ-027 Flags: updated only for scalar ops with SetFlags_i=1; C = carry-out (add) / not-borrow (sub), V = signed overflow; logic ops clear C and V.
REQ-028 NOP SHALL take the scalar path and leave result_S_o, result_V_o and flags_o unchanged.
REQ-029 Results SHALL hold their value until the next completing operation.

Reset
REQ-030 RST low SHALL asynchronously force IDLE, index 0, result_S_o 0, result_V_o 0, flags_o 0, busy_o 0, Exe_Finished_o 0, including mid-BUSY.
REQ-031 An operation interrupted by reset SHALL never signal Exe_Finished_o.

Configuration
REQ-032 With VEC_SATURATE_EN defined, vector add/sub SHALL saturate unsigned per element (clamp to 2^L-1 / 0).
REQ-033 Without VEC_SATURATE_EN, vector add/sub SHALL wrap modulo 2^L; scalar ops wrap in both builds.

Structure
REQ-034 Package asip_pkg SHALL hold the OpType and ALUControl enums and the FSM state typedef.
REQ-035 Sub-module vector_lane_alu SHALL implement one L-bit lane (op, saturate option); P instances form the per-cycle slice.

Verification
REQ-036 Scalar add RD1_S=5, Extend=7, ALUSource=1, SetFlags=1 -> result_S_o=12, flags 0000, Exe_Finished_o one cycle after start.
REQ-037 Scalar sub 3-3, SetFlags=1 -> result_S_o=0, Z=1, C=1; SetFlags=0 repeat -> flags unchanged.
REQ-038 Vector-vector add, RD1_V[i]=i, RD2_V[i]=2i -> result_V_o[i]=3i for all 20 elements, Exe_Finished_o exactly 6 cycles after start, busy_o high 5+1 cycles.
REQ-039 Vector-scalar add 0xF0 + 0x20 -> 0x10 per element without macro, 0xFF with VEC_SATURATE_EN.
REQ-040 start_i with new operands held high during BUSY -> ignored; first result unchanged, second op accepted only after return to IDLE.
REQ-041 RST low at cycle 3 of a vector op -> all outputs 0 immediately, no Exe_Finished_o pulse, next start behaves normally.
